// File: rtl/noc_pkg.sv
// Shared definitions for the buffered mesh router: port indices, flit field offsets,
// XY route computation and a saturating counter helper.
package noc_pkg;

    localparam int NUM_PORTS = 5;

    localparam logic [2:0] P_LOCAL   = 3'd0;
    localparam logic [2:0] P_LEFT    = 3'd1;
    localparam logic [2:0] P_RIGHT   = 3'd2;
    localparam logic [2:0] P_UP      = 3'd3;
    localparam logic [2:0] P_DOWN    = 3'd4;
    localparam logic [2:0] P_INVALID = 3'd7;

    // Flit layout, MSB first: dest_x | dest_y | payload.
    function automatic int dest_x_lsb(input int coord_w, input int data_w);
        return coord_w + data_w;
    endfunction

    function automatic int dest_y_lsb(input int data_w);
        return data_w;
    endfunction

    // X is resolved before Y; coordinates are 1-based, so 0 is never a valid destination.
    function automatic logic [2:0] route_xy(input logic [31:0] dest_x, input logic [31:0] dest_y,
                                            input logic [31:0] here_x, input logic [31:0] here_y,
                                            input logic [31:0] mesh_w, input logic [31:0] mesh_h);
        if (dest_x == 0 || dest_y == 0 || dest_x > mesh_w || dest_y > mesh_h) return P_INVALID;
        if (dest_x > here_x) return P_RIGHT;
        if (dest_x < here_x) return P_LEFT;
        if (dest_y > here_y) return P_DOWN;
        if (dest_y < here_y) return P_UP;
        return P_LOCAL;
    endfunction

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [2:0] n);
        logic [16:0] s;
        s = {1'b0, a} + 17'(n);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/mesh_router_buffered_if.sv
// Five-port flit bundle between a mesh router and its environment.
// With ROUTER_STATS_EN defined the bundle also carries drop_count and fwd_count.
interface mesh_router_buffered_if
    import noc_pkg::*;
#(
    parameter int COORD_W = 16,
    parameter int DATA_W  = 32
);
    localparam int FLIT_W = 2 * COORD_W + DATA_W;

    // Per port: a flit moves on a clock edge where valid and ready are both 1; the sender
    // holds valid and the flit steady until then, ready never depends on valid.
    logic [NUM_PORTS*FLIT_W-1:0] in_flit;
    logic [NUM_PORTS-1:0]        in_valid;
    logic [NUM_PORTS-1:0]        in_ready;
    logic [NUM_PORTS*FLIT_W-1:0] out_flit;
    logic [NUM_PORTS-1:0]        out_valid;
    logic [NUM_PORTS-1:0]        out_ready;
`ifdef ROUTER_STATS_EN
    logic [15:0]                 drop_count;
    logic [15:0]                 fwd_count;
`endif

    modport master (
        output in_flit, in_valid, out_ready,
        input  in_ready, out_flit, out_valid
`ifdef ROUTER_STATS_EN
        , input drop_count, fwd_count
`endif
    );

    modport slave (
        input  in_flit, in_valid, out_ready,
        output in_ready, out_flit, out_valid
`ifdef ROUTER_STATS_EN
        , output drop_count, fwd_count
`endif
    );

endinterface

// File: rtl/router_fifo.sv
// Synchronous FIFO for one router input; a separate count distinguishes full from empty.
module router_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is refused even if a pop happens on the same edge.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mesh_router_buffered.sv
// Five-port XY mesh router: per-input FIFOs, round-robin per output, one holding register per output.
// Defining ROUTER_STATS_EN adds saturating drop_count / fwd_count on the interface.
module mesh_router_buffered
    import noc_pkg::*;
#(
    parameter int X_COORD    = 1,
    parameter int Y_COORD    = 1,
    parameter int MESH_W     = 3,
    parameter int MESH_H     = 3,
    parameter int COORD_W    = 16,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input logic                   clk,
    input logic                   rst,
    mesh_router_buffered_if.slave noc
);
    localparam int FLIT_W = 2 * COORD_W + DATA_W;
    localparam int DX_LSB = dest_x_lsb(COORD_W, DATA_W);
    localparam int DY_LSB = dest_y_lsb(DATA_W);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    logic [NUM_PORTS-1:0]             fifo_full, fifo_empty, push, pop, head_bad;
    logic [NUM_PORTS-1:0][CNT_W-1:0]  fifo_count;
    logic [FLIT_W-1:0]                head_flit  [NUM_PORTS];
    logic [2:0]                       head_route [NUM_PORTS];

    logic [FLIT_W-1:0]                out_flit_q [NUM_PORTS];
    logic [NUM_PORTS-1:0]             out_valid_q, gnt_vld, load_ok, fire;
    logic [2:0]                       gnt_idx    [NUM_PORTS];
    logic [2:0]                       rr_ptr     [NUM_PORTS];

    wire unused_count = ^fifo_count;

    assign noc.in_ready = {NUM_PORTS{rst}} & ~fifo_full;
    assign push         = noc.in_valid & noc.in_ready;
    assign fire         = out_valid_q & noc.out_ready;
    assign load_ok      = ~out_valid_q | noc.out_ready;
    assign noc.out_valid = out_valid_q;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_in
        router_fifo #(.WIDTH(FLIT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[p]),
            .pop   (pop[p]),
            .din   (noc.in_flit[p*FLIT_W +: FLIT_W]),
            .dout  (head_flit[p]),
            .full  (fifo_full[p]),
            .empty (fifo_empty[p]),
            .count (fifo_count[p])
        );

        assign head_route[p] = route_xy(32'(head_flit[p][DX_LSB +: COORD_W]),
                                        32'(head_flit[p][DY_LSB +: COORD_W]),
                                        32'(X_COORD), 32'(Y_COORD), 32'(MESH_W), 32'(MESH_H));
        assign head_bad[p]   = ~fifo_empty[p] & (head_route[p] == P_INVALID);
    end

    always_comb begin
        noc.out_flit = '0;
        for (int o = 0; o < NUM_PORTS; o++) noc.out_flit[o*FLIT_W +: FLIT_W] = out_flit_q[o];
    end

    // Each head requests exactly one output, so at most one grant per input per cycle.
    // Invalid heads are popped unconditionally and never reach an output.
    always_comb begin
        int         sum;
        logic [2:0] cand;
        sum  = 0;
        cand = 3'd0;
        pop  = head_bad;
        for (int o = 0; o < NUM_PORTS; o++) begin
            gnt_vld[o] = 1'b0;
            gnt_idx[o] = 3'd0;
            for (int i = 1; i <= NUM_PORTS; i++) begin
                sum  = int'(rr_ptr[o]) + i;
                cand = 3'(sum % NUM_PORTS);
                if (!gnt_vld[o] && load_ok[o] && !fifo_empty[cand] && head_route[cand] == 3'(o)) begin
                    gnt_vld[o] = 1'b1;
                    gnt_idx[o] = cand;
                end
            end
            if (gnt_vld[o]) pop[gnt_idx[o]] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_q <= '0;
            for (int o = 0; o < NUM_PORTS; o++) begin
                out_flit_q[o] <= '0;
                rr_ptr[o]     <= P_DOWN;
            end
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (gnt_vld[o]) begin
                    out_flit_q[o]  <= head_flit[gnt_idx[o]];
                    out_valid_q[o] <= 1'b1;
                    rr_ptr[o]      <= gnt_idx[o];
                end else if (fire[o]) begin
                    out_valid_q[o] <= 1'b0;
                end
            end
        end
    end

`ifdef ROUTER_STATS_EN
    logic [15:0] drop_q, fwd_q;
    logic [2:0]  n_drop, n_fwd;

    always_comb begin
        n_drop = '0;
        n_fwd  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            n_drop = n_drop + 3'(head_bad[p]);
            n_fwd  = n_fwd + 3'(fire[p]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            drop_q <= '0;
            fwd_q  <= '0;
        end else begin
            drop_q <= sat_add16(drop_q, n_drop);
            fwd_q  <= sat_add16(fwd_q, n_fwd);
        end
    end

    assign noc.drop_count = drop_q;
    assign noc.fwd_count  = fwd_q;
`endif

endmodule

// File: doc/mesh_router_buffered.md
Name: mesh_router_buffered

Overview:
Parametrised successor to the fixed 3x3 mesh router. It is a five-port router (local CPU, left, right, up, down) with per-input FIFOs, deterministic XY routing, per-output round-robin arbitration and valid/ready handshakes on every link. Mesh size, coordinates, payload width and buffer depth are set by parameters. One instance sits at each mesh node between the CPU and its neighbour routers, replacing unbuffered flit passing.

Parameters:
X_COORD, 1, this router's column (1..MESH_W)
Y_COORD, 1, this router's row (1..MESH_H)
MESH_W, 3, mesh columns
MESH_H, 3, mesh rows
COORD_W, 16, width of each destination coordinate field
DATA_W, 32, payload width
FIFO_DEPTH, 4, entries per input FIFO (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
in_flit  in  5*FLIT_W  input flits, port p at [p*FLIT_W +: FLIT_W]; FLIT_W = 2*COORD_W+DATA_W
in_valid  in  5  input flit valid per port
in_ready  out  5  input can accept per port
out_flit  out  5*FLIT_W  output flits, same packing
out_valid  out  5  output flit valid per port
out_ready  in  5  downstream can accept per port
drop_count  out  16  invalid-destination drops (only with ROUTER_STATS_EN)
fwd_count  out  16  flits forwarded (only with ROUTER_STATS_EN)

Behaviour:
- Port index: 0 LOCAL, 1 LEFT (x-1), 2 RIGHT (x+1), 3 UP (y-1), 4 DOWN (y+1).
- Flit layout: [FLIT_W-1 -: COORD_W] dest_x, next COORD_W bits dest_y, [DATA_W-1:0] payload. Forwarded unmodified.
- Reset (rst=0 at a clk edge): FIFOs empty, out_valid=0, out_flit=0, all arbiter pointers=4 (so input 0 has top priority first), counters=0. in_ready=0 while rst=0.
- in_ready[p] = !full[p], registered-count based. No pass-through when full: a push while full is not allowed even if a pop happens in the same cycle. A transfer occurs on an edge with in_valid & in_ready.
- Route of FIFO head, in order: dest_x>X -> RIGHT; dest_x<X -> LEFT; dest_y>Y -> DOWN; dest_y<Y -> UP; else LOCAL.
- Invalid destination (dest_x or dest_y = 0, dest_x>MESH_W, or dest_y>MESH_H): popped and discarded one cycle after reaching the head. No output is produced.
- Each output has one holding register. It may load when empty or when it is being drained that cycle (out_valid & out_ready). out_flit is stable while out_valid=1 and out_ready=0.
- Arbitration per output is round-robin among inputs whose head routes there. Search starts at last_grant+1 mod 5. The pointer updates only on a grant. One grant per input per cycle.
- Latency: flit accepted at edge t into an empty FIFO with no contention -> out_valid high after edge t+1.
- FIFO pointers wrap modulo FIFO_DEPTH. A separate count tracks full vs empty.
- Simultaneous push and pop on a non-full FIFO keeps the count unchanged.
- Reset mid-operation discards all buffered flits with no partial output.

Optional Feature:
ROUTER_STATS_EN
- Defined: adds drop_count and fwd_count.
  - Both are 16-bit and saturate at 0xFFFF.
  - fwd_count increments on each output handshake (multiple per cycle summed, saturating).
  - drop_count increments per discarded flit.
- Undefined: ports and counters are absent. Drop behaviour is unchanged.

Decomposition:
- Package noc_pkg holds:
  - port index constants (P_LOCAL..P_DOWN, NUM_PORTS=5);
  - flit field offset functions;
  - the XY route function returning a port index or an INVALID code.
- Sub-module router_fifo(WIDTH, DEPTH) provides sync FIFO with full/empty/count. It is instantiated five times.
- Arbiters and output registers are generated inline.

Test Plan:
1. Hold rst=0 for 3 cycles with in_valid=5'b11111 -> out_valid=0, in_ready=0, nothing stored. Release -> in_ready=5'b11111.
2. Router (2,2): LOCAL injects dest (3,2), payload 0xDEADBEEF, at edge t, out_ready all 1 -> out_valid[RIGHT]=1 after edge t+1 with an identical flit. dest (2,1) from LEFT -> UP. dest (2,2) from DOWN -> LOCAL.
3. Contention: LEFT and RIGHT both send dest (2,2) in the same cycle, twice in a row -> LOCAL outputs LEFT, RIGHT, LEFT, RIGHT on consecutive cycles.
4. Backpressure: out_ready[RIGHT]=0, LEFT streams 6 flits to (3,2) with FIFO_DEPTH=4 -> 5 accepted (1 in output register, 4 in FIFO), in_ready[LEFT]=0 and out_flit stable. Raise out_ready -> 6 flits delivered in order, one per cycle.
5. Invalid dests (0,2) and (4,1) injected on LOCAL -> no out_valid on any port, in_ready recovers. With ROUTER_STATS_EN, drop_count=2.
6. Assert rst=0 with 3 flits buffered and out_valid[UP]=1 -> after the reset edge out_valid=0. After release no stale flit ever appears.
